// File: rtl/ft_dbg_pkg.sv
// Shared constants, state encoding and CTRL register layout for the FT debug responder.
package ft_dbg_pkg;

  localparam logic [14:0] GPR_BASE  = 15'h0400;
  localparam logic [14:0] NPC_ADDR  = 15'h2000;
  localparam logic [14:0] PPC_ADDR  = 15'h2004;
  localparam logic [14:0] CTRL_ADDR = 15'h0000;

  localparam int HALT_TIMEOUT = 16;
  localparam int TMO_W        = $clog2(HALT_TIMEOUT) + 1;

  localparam int CTRL_HALTED_BIT  = 0;
  localparam int CTRL_TIMEOUT_BIT = 1;

  typedef enum logic [1:0] {
    ST_RUNNING  = 2'd0,
    ST_HALT_REQ = 2'd1,
    ST_HALTED   = 2'd2,
    ST_RESUMING = 2'd3
  } dbg_state_e;

endpackage

// File: rtl/ft_dbg_addr_dec.sv
// Combinational debug-address decode into GPR/NPC/PPC/CTRL selects; no latency, no backpressure.
// Misaligned addresses decode to nothing so they fall through as unmapped.
module ft_dbg_addr_dec
  import ft_dbg_pkg::*;
(
  input  logic [14:0] addr_i,
  output logic        is_gpr_o,
  output logic        is_npc_o,
  output logic        is_ppc_o,
  output logic        is_ctrl_o,
  output logic [4:0]  reg_idx_o
);

  logic aligned;

  assign aligned   = (addr_i[1:0] == 2'b00);
  assign is_gpr_o  = aligned && (addr_i[14:7] == GPR_BASE[14:7]);
  assign is_npc_o  = (addr_i == NPC_ADDR);
  assign is_ppc_o  = (addr_i == PPC_ADDR);
  assign is_ctrl_o = (addr_i == CTRL_ADDR);
  assign reg_idx_o = addr_i[6:2];

endmodule

// File: rtl/ft_dbg_responder.sv
// Per-core debug target: halts/resumes the core and serves GPR/NPC/PPC/CTRL accesses.
// Grant is combinational with no backpressure; rvalid/rdata follow one cycle after grant.
module ft_dbg_responder
  import ft_dbg_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        debug_halt_i,
  input  logic        debug_resume_i,
  output logic        debug_halted_o,
  input  logic        debug_req_i,
  output logic        debug_gnt_o,
  output logic        debug_rvalid_o,
  input  logic [14:0] debug_addr_i,
  input  logic        debug_we_i,
  input  logic [31:0] debug_wdata_i,
  output logic [31:0] debug_rdata_o,
  output logic        core_stall_o,
  input  logic        core_idle_i,
  input  logic [31:0] pc_i,
  output logic [4:0]  rf_raddr_o,
  input  logic [31:0] rf_rdata_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        npc_we_o,
  output logic [31:0] npc_o
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(HALT_TIMEOUT - 1);

  dbg_state_e        state_q, state_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d;
  logic              tmo_q, tmo_d;
  logic              dirty_q, dirty_d;
  logic [31:0]       ppc_q, ppc_d;
  logic [31:0]       npc_q, npc_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              is_gpr, is_npc, is_ppc, is_ctrl;
  logic [4:0]        reg_idx;
  logic              halted, acc_rd, acc_wr, gpr_nz;
  logic [31:0]       ctrl;

  ft_dbg_addr_dec u_dec (
    .addr_i    (debug_addr_i),
    .is_gpr_o  (is_gpr),
    .is_npc_o  (is_npc),
    .is_ppc_o  (is_ppc),
    .is_ctrl_o (is_ctrl),
    .reg_idx_o (reg_idx)
  );

  assign halted         = (state_q == ST_HALTED);
  assign acc_rd         = debug_req_i && !debug_we_i;
  assign acc_wr         = debug_req_i && debug_we_i;
  assign gpr_nz         = is_gpr && (reg_idx != 5'd0);

  assign debug_halted_o = halted;
  assign core_stall_o   = (state_q != ST_RUNNING);
  assign debug_gnt_o    = debug_req_i;
  assign debug_rvalid_o = rvalid_q;
  assign debug_rdata_o  = rdata_q;
  assign npc_o          = npc_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    dirty_d    = dirty_q;
    ppc_d      = ppc_q;
    npc_d      = npc_q;
    npc_we_o   = 1'b0;
    rvalid_d   = debug_req_i;
    rdata_d    = 32'd0;
    rf_we_o    = 1'b0;
    rf_waddr_o = 5'd0;
    rf_wdata_o = 32'd0;
    rf_raddr_o = 5'd0;
    ctrl       = 32'd0;
    ctrl[CTRL_HALTED_BIT]  = halted;
    ctrl[CTRL_TIMEOUT_BIT] = tmo_q;

    case (state_q)
      ST_RUNNING: begin
        if (debug_halt_i) begin
          state_d = ST_HALT_REQ;
          cnt_d   = '0;
        end
      end
      // Once requested, a halt always completes even if halt_i drops.
      ST_HALT_REQ: begin
        if (core_idle_i) begin
          state_d = ST_HALTED;
          ppc_d   = pc_i;
        end else if (cnt_q == TMO_LAST) begin
          state_d = ST_HALTED;
          ppc_d   = pc_i;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HALTED: begin
        if (debug_resume_i && !debug_halt_i) begin
          state_d = ST_RESUMING;
        end
      end
      ST_RESUMING: begin
        npc_we_o = dirty_q;
        dirty_d  = 1'b0;
        state_d  = ST_RUNNING;
      end
      default: state_d = ST_RUNNING;
    endcase

    if (acc_wr && halted) begin
      if (gpr_nz) begin
        rf_we_o    = 1'b1;
        rf_waddr_o = reg_idx;
        rf_wdata_o = debug_wdata_i;
      end else if (is_npc) begin
        npc_d   = debug_wdata_i;
        dirty_d = 1'b1;
      end
    end

    if (acc_rd) begin
      if (halted && is_gpr) begin
        rf_raddr_o = reg_idx;
        rdata_d    = gpr_nz ? rf_rdata_i : 32'd0;
      end else if (halted && is_npc) begin
        rdata_d = dirty_q ? npc_q : ppc_q;
      end else if (is_ppc) begin
        rdata_d = ppc_q;
      end else if (is_ctrl) begin
        rdata_d = ctrl;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_RUNNING;
      cnt_q    <= '0;
      tmo_q    <= 1'b0;
      dirty_q  <= 1'b0;
      ppc_q    <= 32'd0;
      npc_q    <= 32'd0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      dirty_q  <= dirty_d;
      ppc_q    <= ppc_d;
      npc_q    <= npc_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule
